// File: rtl/mem_boot_loader.sv
// mem_boot_loader: streams a program image into Memory, verifies it by readback, then hands the port to the CPU
module mem_boot_loader #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 cpu_we,
  input  logic [addWidth-1:0]  cpu_addr,
  input  logic [dataWidth-1:0] cpu_wdata,
  output logic                 mem_we,
  output logic [addWidth-1:0]  mem_addr,
  output logic [dataWidth-1:0] mem_wdata,
  input  logic [dataWidth-1:0] mem_rdata,
  output logic                 cpu_run,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);
  localparam int CW = addWidth + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {addWidth{1'b0}}};
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERR} state_t;
  state_t state;
  logic [CW-1:0] n, wcnt, rcnt, len;
  logic [dataWidth-1:0] load_x, read_x;
  logic [1:0] code;
  logic beat, len_bad;
  always_comb begin
    len       = s_data[addWidth:0];
    len_bad   = (|(s_data >> CW)) || (len > CAP);
    s_ready   = state == LEN || state == DATA || state == CSUM;
    beat      = s_valid & s_ready;
    mem_we    = state == DATA ? s_valid : state == DONE ? cpu_we : 1'b0;
    mem_addr  = state == DATA ? wcnt[addWidth-1:0] : state == VERIFY ? rcnt[addWidth-1:0] :
                state == DONE ? cpu_addr : '0;
    mem_wdata = state == DATA ? s_data : state == DONE ? cpu_wdata : '0;
    cpu_run   = state == DONE;
    done      = state == DONE;
    error     = state == ERR;
    err_code  = code;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      n      <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
      load_x <= '0;
      read_x <= '0;
      code   <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state  <= LEN;
          n      <= '0;
          wcnt   <= '0;
          rcnt   <= '0;
          load_x <= '0;
          read_x <= '0;
          code   <= '0;
        end
        LEN: if (beat) begin
          n     <= len;
          state <= len_bad ? ERR : len == '0 ? CSUM : DATA;
          if (len_bad) code <= 2'd3;
        end
        // the Memory write for this word lands on the same edge as the beat
        DATA: if (beat) begin
          load_x <= load_x ^ s_data;
          wcnt   <= wcnt + 1'b1;
          if (wcnt == n - 1'b1) state <= CSUM;
        end
        CSUM: if (beat) begin
          state <= s_data != load_x ? ERR : VERIFY;
          rcnt  <= '0;
          if (s_data != load_x) code <= 2'd1;
        end
        // N read cycles accumulate, one more cycle compares
        VERIFY: if (rcnt < n) begin
          read_x <= read_x ^ mem_rdata;
          rcnt   <= rcnt + 1'b1;
        end else begin
          state <= read_x == load_x ? DONE : ERR;
          if (read_x != load_x) code <= 2'd2;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: table-driven load scenarios against a behavioural Memory, plus reset/handover sequences
module tb_mem_boot_loader;
  localparam int AW = 6, DW = 32;
  logic clk = 0, reset = 1, start = 0, s_valid = 0, cpu_we = 0;
  logic [DW-1:0] s_data = 0, cpu_wdata = 0, mem_rdata;
  logic [AW-1:0] cpu_addr = 0;
  logic s_ready, mem_we, cpu_run, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0] err_code;
  logic [DW-1:0] mem [64];
  bit bad_rd = 0;
  int we_total = 0;
  int checks = 0, errors = 0;

  mem_boot_loader #(.addWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_run(cpu_run), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) begin
    mem[mem_addr] <= mem_wdata;
    we_total <= we_total + 1;
  end
  assign mem_rdata = mem[mem_addr] ^ ((bad_rd && mem_addr == 6'd1) ? 32'h1 : 32'h0);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] len_word;
    int          nw;
    logic [31:0] d0, d1, d2;
    logic [31:0] cdelta;
    bit          gaps;
    bit          bad;
    bit          exp_done;
    logic [1:0]  exp_code;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    bit sent = 0;
    s_valid = 1;
    s_data = w;
    for (int t = 0; t < 20 && !sent; t++) begin
      @(negedge clk);
      sent = s_ready;
      @(posedge clk); #1;
    end
    if (!sent) chk("ready_timeout", 0, 1);
    s_valid = 0;
    s_data = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (v.nw <= 3) return i == 0 ? v.d0 : i == 1 ? v.d1 : v.d2;
    return (i * 32'h0103_0507) ^ 32'hA5A5_0000;
  endfunction

  initial begin
    logic [31:0] x, w;
    int w0, cyc, exp_cyc;
    vt[0] = '{32'd3, 3, 32'h11, 32'h22, 32'h44, 32'h0, 0, 0, 1, 2'd0};
    vt[1] = '{32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 2'd0};
    vt[2] = '{32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h5, 0, 0, 0, 2'd1};
    vt[3] = '{32'd3, 3, 32'h1, 32'h2, 32'h3, 32'h5, 0, 0, 0, 2'd1};
    vt[4] = '{32'd65, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 2'd3};
    vt[5] = '{32'h100, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 2'd3};
    vt[6] = '{32'h8000_0003, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 2'd3};
    vt[7] = '{32'd3, 3, 32'h11, 32'h22, 32'h44, 32'h0, 0, 1, 0, 2'd2};
    vt[8] = '{32'd64, 64, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1, 2'd0};

    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_outs", {s_ready, mem_we, cpu_run, done, error, err_code}, 0);
    chk("reset_addr", {mem_addr, mem_wdata}, 0);

    foreach (vt[k]) begin
      bad_rd = vt[k].bad;
      pulse_start();
      @(negedge clk);
      chk($sformatf("v%0d_len_ready", k), s_ready, 1);
      chk($sformatf("v%0d_start_clr", k), {done, error, cpu_run, err_code}, 0);
      @(posedge clk); #1;
      cpu_we = 1; cpu_addr = 6'd40; cpu_wdata = 32'hBAD0_0000 + k;
      w0 = we_total;
      x = 0;
      send(vt[k].len_word);
      if (vt[k].exp_code != 2'd3) begin
        for (int i = 0; i < vt[k].nw; i++) begin
          if (vt[k].gaps && i > 0) begin
            s_valid = 0; s_data = 32'hDEAD_BEEF;
            @(negedge clk);
            chk($sformatf("v%0d_gap_we", k), mem_we, 0);
            @(posedge clk); #1;
          end
          w = word_of(vt[k], i);
          send(w);
          x ^= w;
        end
        send(x ^ vt[k].cdelta);
      end
      cyc = 0;
      while (!(done || error) && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      cpu_we = 0;
      exp_cyc = (vt[k].exp_code == 2'd1 || vt[k].exp_code == 2'd3) ? 0 : vt[k].nw + 1;
      chk($sformatf("v%0d_verify_cycles", k), cyc, exp_cyc);
      chk($sformatf("v%0d_done", k), {done, cpu_run}, {2{vt[k].exp_done}});
      chk($sformatf("v%0d_error", k), error, !vt[k].exp_done);
      chk($sformatf("v%0d_err_code", k), err_code, vt[k].exp_code);
      chk($sformatf("v%0d_we_count", k), we_total - w0, vt[k].exp_code == 2'd3 ? 0 : vt[k].nw);
      if (vt[k].exp_code != 2'd3)
        for (int i = 0; i < vt[k].nw; i++) chk($sformatf("v%0d_mem%0d", k, i), mem[i], word_of(vt[k], i));
      bad_rd = 0;
    end

    cpu_we = 1; cpu_addr = 6'd5; cpu_wdata = 32'hABCD_1234;
    @(negedge clk);
    chk("done_pass_we", {mem_we, mem_addr}, {1'b1, 6'd5});
    chk("done_pass_wdata", mem_wdata, 32'hABCD_1234);
    @(posedge clk); #1;
    cpu_we = 0;
    chk("done_cpu_write", mem[5], 32'hABCD_1234);
    pulse_start();
    @(negedge clk);
    chk("restart_len", {cpu_run, done, s_ready}, 3'b001);
    chk("len_addr_wdata", {mem_addr, mem_wdata}, 0);

    @(posedge clk); #1;
    send(32'd5);
    send(32'h55);
    send(32'h66);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    s_valid = 1; s_data = 32'h77;
    #1;
    chk("start_ignored_data", {mem_we, mem_addr}, {1'b1, 6'd2});
    s_valid = 0; s_data = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midload_reset_outs", {s_ready, mem_we, cpu_run, done, error, err_code}, 0);
    chk("midload_reset_addr", {mem_addr, mem_wdata}, 0);
    chk("midload_mem0", mem[0], 32'h55);
    chk("midload_mem1", mem[1], 32'h66);
    s_valid = 1; s_data = 32'hFFFF_FFFF;
    #1;
    chk("idle_ignores_stream", {s_ready, mem_we}, 0);
    s_valid = 0; s_data = 0;

    @(posedge clk); #1;
    pulse_start();
    send(32'd1);
    send(32'h1234);
    send(32'h1234);
    cyc = 0;
    while (!(done || error) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("idle_load_cycles", cyc, 2);
    chk("idle_load_done", {done, cpu_run, error, err_code}, 5'b11000);
    chk("idle_load_mem0", mem[0], 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
